spi_arbiter: RTL

Round-robin arbiter and transaction sequencer that shares one spi_master instance among N_REQ client requesters, each owning one SPI slave.
- Accepts a one-word request per client, issues the spi_master start pulse and data, and waits for done or a timeout.
- Returns the received word to the owning client.
- Routes the master's chip select to the granted slave only.
- Sits between client logic and spi_master; all SPI pins except the per-slave chip selects come straight from spi_master.

---
 rtl/spi_arbiter_if.sv | 44 ++++
 rtl/spi_arbiter.sv | 135 +++++++++++++
 2 files changed

// File: rtl/spi_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_arbiter_if                                            |
// | Purpose  : Client request/response bus plus spi_master control lines |
// |            shared between spi_arbiter and its surroundings.          |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface spi_arbiter_if #(
    parameter int N_REQ       = 4,
    parameter int DATA_LENGTH = 8
);
    // client side
    logic [N_REQ-1:0]             req_valid;
    logic [N_REQ*DATA_LENGTH-1:0] req_data;
    logic [N_REQ-1:0]             req_ready;
    logic [N_REQ-1:0]             rsp_valid;
    logic [DATA_LENGTH-1:0]       rsp_data;
    logic                         rsp_err;
    // spi_master side
    logic                         m_start;
    logic [DATA_LENGTH-1:0]       m_data_in;
    logic                         m_busy;
    logic                         m_done;
    logic [DATA_LENGTH-1:0]       m_data_out;
    logic                         m_cs_n;
    // per-slave chip selects
    logic [N_REQ-1:0]             slave_cs_n;

    // master: the arbiter itself, which owns grants, responses and the
    // spi_master controls
    modport master (
        input  req_valid, req_data, m_busy, m_done, m_data_out, m_cs_n,
        output req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_data_in,
               slave_cs_n
    );

    // slave: the clients and spi_master surrounding the arbiter
    modport slave (
        output req_valid, req_data, m_busy, m_done, m_data_out, m_cs_n,
        input  req_ready, rsp_valid, rsp_data, rsp_err, m_start, m_data_in,
               slave_cs_n
    );
endinterface
`default_nettype wire

// File: rtl/spi_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : spi_arbiter                                               |
// | Purpose  : Round-robin arbiter and transaction sequencer sharing one |
// |            spi_master among N_REQ clients, one slave per client.     |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module spi_arbiter #(
    parameter int N_REQ          = 4,
    parameter int DATA_LENGTH    = 8,
    parameter int TIMEOUT_CYCLES = 256,
    parameter int GUARD_CYCLES   = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_arbiter_if.master bus
);
    localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int GD_W  = $clog2(GUARD_CYCLES + 1);

    localparam logic [TO_W-1:0]  TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [GD_W-1:0]  GD_LAST = GD_W'(GUARD_CYCLES - 1);
    localparam logic [IDX_W-1:0] PTR_RST = IDX_W'(N_REQ - 1);
    localparam logic [N_REQ-1:0] ONE     = {{(N_REQ-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        WAIT  = 3'd2,
        RESP  = 3'd3,
        GAP   = 3'd4
    } state_t;

    state_t           state;
    logic [IDX_W-1:0] gnt_idx;
    logic [IDX_W-1:0] rr_ptr;
    logic [TO_W-1:0]  to_cnt;
    logic [GD_W-1:0]  gd_cnt;

    logic [IDX_W-1:0] winner;
    logic [IDX_W-1:0] cand;
    logic             grant_ok;

    // Round-robin pick: scan downward so the last hit is the first
    // asserted request above rr_ptr (wrapping modulo N_REQ).
    always_comb begin
        winner = rr_ptr;
        cand   = '0;
        for (int k = N_REQ; k >= 1; k--) begin
            cand = IDX_W'((int'(rr_ptr) + k) % N_REQ);
            if (bus.req_valid[cand]) begin
                winner = cand;
            end
        end
    end

    // A new grant needs a request and a fully quiet spi_master, which also
    // keeps a timed-out master from being restarted while it still runs.
    assign grant_ok = (|bus.req_valid) && !bus.m_busy && !bus.m_done;

    // Sequencer: arbitration, start pulse, wait/timeout, response, guard gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            gnt_idx       <= '0;
            rr_ptr        <= PTR_RST;
            to_cnt        <= '0;
            gd_cnt        <= '0;
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.rsp_data  <= '0;
            bus.rsp_err   <= 1'b0;
            bus.m_start   <= 1'b0;
            bus.m_data_in <= '0;
        end else begin
            bus.req_ready <= '0;
            bus.rsp_valid <= '0;
            bus.m_start   <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant_ok) begin
                        gnt_idx       <= winner;
                        bus.m_data_in <= bus.req_data[winner*DATA_LENGTH +: DATA_LENGTH];
                        bus.m_start   <= 1'b1;
                        bus.req_ready <= ONE << winner;
                        state         <= START;
                    end
                end
                START: begin
                    rr_ptr <= gnt_idx;
                    to_cnt <= '0;
                    state  <= WAIT;
                end
                WAIT: begin
                    if (bus.m_done) begin
                        bus.rsp_data  <= bus.m_data_out;
                        bus.rsp_err   <= 1'b0;
                        bus.rsp_valid <= ONE << gnt_idx;
                        state         <= RESP;
                    end else if (to_cnt == TO_LAST) begin
                        bus.rsp_data  <= '0;
                        bus.rsp_err   <= 1'b1;
                        bus.rsp_valid <= ONE << gnt_idx;
                        state         <= RESP;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                RESP: begin
                    gd_cnt <= '0;
                    state  <= GAP;
                end
                GAP: begin
                    if (gd_cnt == GD_LAST) begin
                        state <= IDLE;
                    end else begin
                        gd_cnt <= gd_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Chip select routing: only the granted slave follows the master's CS,
    // and only while its transaction is in flight.
    always_comb begin
        bus.slave_cs_n = '1;
        if (state == START || state == WAIT || state == RESP) begin
            bus.slave_cs_n[gnt_idx] = bus.m_cs_n;
        end
    end
endmodule
`default_nettype wire
